// File: rtl/mult_div_unit.sv
// Iterative WIDTH-bit multiply/divide unit: shift-add multiply, restoring divide, HI/LO results.
// Define MULTDIV_SIGNED_EN for two's-complement (mult/div) semantics; otherwise multu/divu.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             RESET_in,
    input  logic             MultOp,
    input  logic             DivOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             Div0
);
    // state | meaning
    // IDLE  | waiting for MultOp/DivOp
    // MULT  | shift-add iterations
    // DIV   | restoring-division iterations
    // FIX   | sign fix-up, HI/LO write, done pulse
    typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     msum, dshift, ddiff;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               last_iter, start_mult, start_div, div_zero;

`ifdef MULTDIV_SIGNED_EN
    logic sign_a, sign_b, op_div;
    assign mag_a = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign mag_b = B[WIDTH-1] ? (~B + 1'b1) : B;
`else
    assign mag_a = A;
    assign mag_b = B;
`endif

    assign last_iter  = (cnt == CW'(WIDTH-1));
    assign start_mult = (state == IDLE) && MultOp;
    assign start_div  = (state == IDLE) && DivOp && !MultOp && (B != '0);
    assign div_zero   = (state == IDLE) && DivOp && !MultOp && (B == '0);
    assign busy       = (state != IDLE);

    // multiply step: add multiplicand into upper half when the multiplier LSB is set
    assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // divide step: {rem, quo} << 1, then trial-subtract the divisor
    assign dshift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign ddiff  = dshift - {1'b0, opnd};

    always_comb begin
        res_hi = acc[2*WIDTH-1:WIDTH];
        res_lo = acc[WIDTH-1:0];
`ifdef MULTDIV_SIGNED_EN
        if (op_div) begin
            if (sign_a ^ sign_b) res_lo = ~acc[WIDTH-1:0] + 1'b1;
            if (sign_a)          res_hi = ~acc[2*WIDTH-1:WIDTH] + 1'b1;
        end else if (sign_a ^ sign_b) begin
            {res_hi, res_lo} = ~acc + 1'b1;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start_mult) state_nxt = MULT;
                       else if (start_div) state_nxt = DIV;
            MULT, DIV: if (last_iter) state_nxt = FIX;
            FIX:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge RESET_in) begin
        if (!RESET_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge clock or negedge RESET_in) begin
        if (!RESET_in) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            HI     <= '0;
            LO     <= '0;
            done   <= 1'b0;
            Div0   <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            op_div <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_mult || start_div) begin
                        acc  <= {{WIDTH{1'b0}}, (start_div ? mag_a : mag_b)};
                        opnd <= start_div ? mag_b : mag_a;
                        Div0 <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
                        sign_a <= A[WIDTH-1];
                        sign_b <= B[WIDTH-1];
                        op_div <= start_div;
`endif
                    end else if (div_zero) begin
                        Div0 <= 1'b1;
                    end
                end
                MULT: begin
                    acc <= {msum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= {(ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0]),
                            acc[WIDTH-2:0], ~ddiff[WIDTH]};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    HI   <= res_hi;
                    LO   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit; expectations follow MULTDIV_SIGNED_EN when defined.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         RESET_in = 1'b1;
    logic         MultOp = 1'b0;
    logic         DivOp = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] HI, LO;
    logic         busy, done, Div0;

    int errors = 0;
    int checks = 0;
    int lat, busy_n, done_n;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .RESET_in(RESET_in), .MultOp(MultOp), .DivOp(DivOp),
        .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .done(done), .Div0(Div0)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start at a negedge; returns at the negedge after the accepting edge E0.
    task automatic start(input logic is_mult, input logic [W-1:0] a, input logic [W-1:0] b);
        A = a; B = b; MultOp = is_mult; DivOp = !is_mult;
        @(negedge clock);
        MultOp = 1'b0; DivOp = 1'b0;
    endtask

    // Sample index first = cycles since E0 at the current negedge; lat = index where done seen.
    task automatic wait_done(input int first, output int lat_o, output int busy_o);
        lat_o = 0; busy_o = 0;
        for (int i = first; i <= first + 100 && lat_o == 0; i++) begin
            if (busy) busy_o++;
            if (done) lat_o = i;
            else @(negedge clock);
        end
    endtask

    initial begin
        #1 RESET_in = 1'b0;
        #2;
        check("reset_hi", HI, '0);
        check("reset_lo", LO, '0);
        check("reset_busy", {31'b0, busy}, '0);
        check("reset_done", {31'b0, done}, '0);
        check("reset_div0", {31'b0, Div0}, '0);
        repeat (2) @(negedge clock);
        RESET_in = 1'b1;
        @(negedge clock);

        // 7 * -3
        start(1'b1, 32'd7, 32'hFFFF_FFFD);
        check("mul1_busy_after_e0", {31'b0, busy}, 32'd1);
        wait_done(1, lat, busy_n);
        check("mul1_latency", lat, 32'd34);
        check("mul1_busy_cycles", busy_n, 32'd33);
`ifdef MULTDIV_SIGNED_EN
        check("mul1_hi", HI, 32'hFFFF_FFFF);
`else
        check("mul1_hi", HI, 32'h0000_0006);
`endif
        check("mul1_lo", LO, 32'hFFFF_FFEB);
        @(negedge clock);
        check("mul1_done_one_cycle", {31'b0, done}, '0);

        // -7 / 2
        start(1'b0, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, lat, busy_n);
        check("div1_latency", lat, 32'd34);
`ifdef MULTDIV_SIGNED_EN
        check("div1_lo", LO, 32'hFFFF_FFFD);
        check("div1_hi", HI, 32'hFFFF_FFFF);
`else
        check("div1_lo", LO, 32'h7FFF_FFFC);
        check("div1_hi", HI, 32'h0000_0001);
`endif
        @(negedge clock);

        // 5 / 0
        start(1'b0, 32'd5, 32'd0);
        check("div0_flag", {31'b0, Div0}, 32'd1);
        check("div0_busy", {31'b0, busy}, '0);
        done_n = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_n++;
            @(negedge clock);
        end
        check("div0_no_done", done_n, '0);
        check("div0_flag_held", {31'b0, Div0}, 32'd1);
`ifdef MULTDIV_SIGNED_EN
        check("div0_hi_kept", HI, 32'hFFFF_FFFF);
        check("div0_lo_kept", LO, 32'hFFFF_FFFD);
`else
        check("div0_hi_kept", HI, 32'h0000_0001);
        check("div0_lo_kept", LO, 32'h7FFF_FFFC);
`endif

        // 2 * 3 clears Div0
        start(1'b1, 32'd2, 32'd3);
        check("mul2_div0_cleared", {31'b0, Div0}, '0);
        wait_done(1, lat, busy_n);
        check("mul2_latency", lat, 32'd34);
        check("mul2_hi", HI, 32'd0);
        check("mul2_lo", LO, 32'd6);

        // back-to-back start on the done cycle: 0xFFFFFFFF * 2
        start(1'b1, 32'hFFFF_FFFF, 32'd2);
        wait_done(1, lat, busy_n);
        check("mul3_latency", lat, 32'd34);
`ifdef MULTDIV_SIGNED_EN
        check("mul3_hi", HI, 32'hFFFF_FFFF);
`else
        check("mul3_hi", HI, 32'h0000_0001);
`endif
        check("mul3_lo", LO, 32'hFFFF_FFFE);
        @(negedge clock);

        // DivOp pulse during iteration 10 of 0x80000000^2 is ignored
        start(1'b1, 32'h8000_0000, 32'h8000_0000);
        repeat (9) @(negedge clock);
        A = 32'd1; B = 32'd0; DivOp = 1'b1;
        @(negedge clock);
        DivOp = 1'b0;
        check("mul4_div0_not_set", {31'b0, Div0}, '0);
        wait_done(11, lat, busy_n);
        check("mul4_latency", lat, 32'd34);
        check("mul4_hi", HI, 32'h4000_0000);
        check("mul4_lo", LO, 32'h0000_0000);
        @(negedge clock);

        // 0x80000000 / 0xFFFFFFFF
        start(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, lat, busy_n);
        check("div2_latency", lat, 32'd34);
`ifdef MULTDIV_SIGNED_EN
        check("div2_lo", LO, 32'h8000_0000);
        check("div2_hi", HI, 32'h0000_0000);
`else
        check("div2_lo", LO, 32'h0000_0000);
        check("div2_hi", HI, 32'h8000_0000);
`endif
        check("div2_no_div0", {31'b0, Div0}, '0);
        @(negedge clock);

        // reset during iteration 20 of a divide
        start(1'b0, 32'd100, 32'd7);
        repeat (19) @(negedge clock);
        check("rst_busy_before", {31'b0, busy}, 32'd1);
        RESET_in = 1'b0;
        #1;
        check("rst_hi", HI, '0);
        check("rst_lo", LO, '0);
        check("rst_busy", {31'b0, busy}, '0);
        check("rst_done", {31'b0, done}, '0);
        check("rst_div0", {31'b0, Div0}, '0);
        @(negedge clock);
        RESET_in = 1'b1;
        @(negedge clock);
        start(1'b1, 32'h1234_5678, 32'h0000_0010);
        wait_done(1, lat, busy_n);
        check("mul5_latency", lat, 32'd34);
        check("mul5_busy_cycles", busy_n, 32'd33);
        check("mul5_hi", HI, 32'h0000_0001);
        check("mul5_lo", LO, 32'h2345_6780);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Iterative 32-bit multiply/divide responder for the multicycle MIPS datapath.
- The control unit raises `MultOp`/`DivOp` and waits in its Mult/Div state. This block runs 32 iterations on the `A`/`B` operands and writes the HI/LO result registers.
- It reports division by zero on `Div0` so the control unit can branch to the exception sequence.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.

Ports:
- `clock` in 1: single clock, rising edge.
- `RESET_in` in 1: asynchronous, active-low reset.
- `MultOp` in 1: start multiply; one-cycle pulse or level, sampled only in IDLE.
- `DivOp` in 1: start divide; sampled only in IDLE.
- `A` in WIDTH: multiplicand / dividend (rs).
- `B` in WIDTH: multiplier / divisor (rt).
- `HI` out WIDTH: product upper half / remainder.
- `LO` out WIDTH: product lower half / quotient.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse when HI/LO have been updated.
- `Div0` out 1: divide attempted with `B == 0`.

## Operation
- States: IDLE, MULT, DIV, FIX.
- IDLE:
  - `MultOp` = 1: latch |A| and |B| plus the sign bits, clear the 64-bit accumulator, counter = 0, go to MULT.
  - `DivOp` = 1, `B != 0`: latch the same way, go to DIV.
  - `DivOp` = 1, `B == 0`: stay in IDLE, set `Div0`, leave HI/LO unchanged.
  - `MultOp` and `DivOp` both high: multiply wins.
- MULT (shift-add): each cycle, if the multiplier LSB is 1, add the multiplicand to the upper accumulator half. Shift the accumulator/multiplier right by 1 and increment the counter. After iteration `WIDTH`, go to FIX.
- DIV (restoring): each cycle, shift {rem, quo} left by 1 and trial-subtract the divisor from rem. If the result is non-negative, keep it and set quo LSB = 1. Increment the counter. After iteration `WIDTH`, go to FIX.
- FIX (signed build only; see Configuration):
  - Multiply: negate the 64-bit product if the operand signs differ.
  - Divide: negate the quotient if the signs differ; give the remainder the sign of the dividend.
  - In all builds: write HI/LO, pulse `done`, return to IDLE.
- Arithmetic:
  - Magnitudes are WIDTH-bit unsigned, so |0x80000000| = 0x80000000.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wraps; no exception).
- `Div0` rules:
  - Registered; stays asserted until the next accepted `MultOp`/`DivOp`, which clears it.
  - Never asserted together with `done`.
- Starts seen while `busy` = 1 are ignored; the operation in progress is not disturbed.
- HI/LO change only in FIX or on reset, and hold their value between operations.

## Timing
- Start accepted on rising edge E0 (IDLE, start input high).
- `busy` = 1 from after E0 through E33.
- Iterations occur on edges E1..E32; FIX happens on E33.
- After E33: HI/LO valid, `done` = 1 for exactly one cycle, `busy` = 0.
- A new start can be accepted on E34 at the earliest, so back-to-back operations take 34 cycles each.
- `Div0` is high from the cycle after E0; `busy` stays 0 on the divide-by-zero path.
- Reset (`RESET_in` = 0, at any time, including mid-operation): state = IDLE, counter = 0, HI = LO = 0, `busy` = `done` = `Div0` = 0. The partial result is discarded.

## Configuration
- `MULTDIV_SIGNED_EN` defined:
  - Operands are two's complement.
  - Magnitude extraction happens at E0 and sign fix-up in FIX (MIPS mult/div semantics).
- Not defined:
  - Operands are unsigned (multu/divu semantics).
  - No magnitude extraction or negation logic; FIX only writes HI/LO.
  - Cycle timing is identical in both builds.

## Test plan
- Multiply 7 × 0xFFFFFFFD (−3), signed build → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; `done` is high exactly 34 cycles after the start edge (visible after E33); `busy` is high for 33 cycles.
- Divide 0xFFFFFFF9 (−7) / 2, signed build → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; unsigned build → LO = 0x7FFFFFFC, HI = 1.
- Divide 5 / 0 → `Div0` = 1 from the next cycle, `busy` = 0, no `done`, HI/LO keep the prior result. A following multiply 2 × 3 clears `Div0` and gives HI = 0, LO = 6.
- Multiply 0xFFFFFFFF × 2: unsigned build → HI = 1, LO = 0xFFFFFFFE; signed build → HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- Assert `DivOp` with new operands at iteration 10 of a multiply 0x80000000 × 0x80000000 → the pulse is ignored; result HI = 0x40000000, LO = 0.
- Drive `RESET_in` low at iteration 20 of a divide → HI = LO = 0, `busy` = `done` = `Div0` = 0 immediately. After release, a new multiply completes normally.
